alarm_trigger: RTL and testbench

ALARM_TRIGGER -- requirements
Module: alarm_trigger

---
 rtl/alarm_pkg.sv | 25 ++
 rtl/alarm_match_detect.sv | 30 +++
 rtl/alarm_trigger.sv | 139 +++++++++++++
 tb/tb_alarm_trigger.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared constants for the alarm trigger: FSM state codes, BCD digit widths
// and default timing values.
package alarm_pkg;

    localparam int HL_W = 2;
    localparam int HR_W = 4;
    localparam int ML_W = 3;
    localparam int MR_W = 4;

    localparam int DEF_RING_TIMEOUT_S = 60;
    localparam int DEF_SNOOZE_S       = 300;
    localparam int DEF_MAX_SNOOZE     = 3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RINGING = 2'd1;
    localparam logic [1:0] ST_SNOOZE  = 2'd2;

    typedef struct packed {
        logic [HL_W-1:0] hours_left;
        logic [HR_W-1:0] hours_right;
        logic [ML_W-1:0] minutes_left;
        logic [MR_W-1:0] minutes_right;
    } bcd_time_t;

endpackage

// File: rtl/alarm_match_detect.sv
// Compares the stored alarm time with the current time and turns the match
// level into a single-cycle trigger on its rising edge.
module alarm_match_detect
    import alarm_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      cfg_valid_i,
    input  logic      alarm_on_i,
    input  bcd_time_t alarm_time_i,
    input  bcd_time_t now_time_i,
    output logic      trigger_o
);

    logic match_d;
    logic match_q;

    assign match_d   = cfg_valid_i & alarm_on_i & (alarm_time_i == now_time_i);
    assign trigger_o = match_d & ~match_q;

    // Clearing match_q on reset lets a match that is still held re-fire once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end

endmodule

// File: rtl/alarm_trigger.sv
// Alarm clock ring/snooze controller: fires on a new time match, beeps at
// 1 Hz, auto-silences after a timeout and supports a limited number of snoozes.
module alarm_trigger
    import alarm_pkg::*;
#(
    parameter int RING_TIMEOUT_S = DEF_RING_TIMEOUT_S,
    parameter int SNOOZE_S       = DEF_SNOOZE_S,
    parameter int MAX_SNOOZE     = DEF_MAX_SNOOZE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick_1hz,
    input  logic            cfg_valid,
    input  logic            alarm_on,
    input  logic [HL_W-1:0] alarm_hours_left,
    input  logic [HR_W-1:0] alarm_hours_right,
    input  logic [ML_W-1:0] alarm_minutes_left,
    input  logic [MR_W-1:0] alarm_minutes_right,
    input  logic [HL_W-1:0] time_hours_left,
    input  logic [HR_W-1:0] time_hours_right,
    input  logic [ML_W-1:0] time_minutes_left,
    input  logic [MR_W-1:0] time_minutes_right,
    input  logic            stop_button,
    input  logic            snooze_button,
    output logic            buzzer,
    output logic            ringing,
    output logic            snoozing,
    output logic [1:0]      snooze_count,
    output logic            alarm_event
);

    localparam int RW = (RING_TIMEOUT_S > 1) ? $clog2(RING_TIMEOUT_S) : 1;
    localparam int SW = (SNOOZE_S > 1) ? $clog2(SNOOZE_S) : 1;
    localparam logic [RW-1:0] RING_LAST = RW'(RING_TIMEOUT_S - 1);
    localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_S - 1);
    localparam logic [1:0]    SNZ_MAX   = 2'(MAX_SNOOZE);

    bcd_time_t alarm_time;
    bcd_time_t now_time;
    logic      trigger;

    logic [1:0]    state_q, state_d;
    logic [RW-1:0] ring_cnt_q, ring_cnt_d;
    logic [SW-1:0] snz_cnt_q, snz_cnt_d;
    logic          beep_q, beep_d;
    logic [1:0]    snooze_count_q, snooze_count_d;
    logic          event_q, event_d;

    assign alarm_time = '{alarm_hours_left, alarm_hours_right,
                          alarm_minutes_left, alarm_minutes_right};
    assign now_time   = '{time_hours_left, time_hours_right,
                          time_minutes_left, time_minutes_right};

    alarm_match_detect u_match (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid_i  (cfg_valid),
        .alarm_on_i   (alarm_on),
        .alarm_time_i (alarm_time),
        .now_time_i   (now_time),
        .trigger_o    (trigger)
    );

    // Cancel (alarm_on low or stop) outranks snooze, which outranks tick expiry.
    always_comb begin
        state_d        = state_q;
        ring_cnt_d     = ring_cnt_q;
        snz_cnt_d      = snz_cnt_q;
        beep_d         = beep_q;
        snooze_count_d = snooze_count_q;
        event_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d        = ST_RINGING;
                    ring_cnt_d     = '0;
                    snooze_count_d = 2'd0;
                    beep_d         = 1'b1;
                    event_d        = 1'b1;
                end
            end
            ST_RINGING: begin
                if (!alarm_on || stop_button) begin
                    state_d = ST_IDLE;
                end else if (snooze_button && (snooze_count_q < SNZ_MAX)) begin
                    state_d        = ST_SNOOZE;
                    snooze_count_d = snooze_count_q + 2'd1;
                    snz_cnt_d      = '0;
                end else if (tick_1hz) begin
                    if (ring_cnt_q == RING_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        ring_cnt_d = ring_cnt_q + RW'(1);
                        beep_d     = ~beep_q;
                    end
                end
            end
            ST_SNOOZE: begin
                if (!alarm_on || stop_button) begin
                    state_d = ST_IDLE;
                end else if (tick_1hz) begin
                    if (snz_cnt_q == SNZ_LAST) begin
                        state_d    = ST_RINGING;
                        ring_cnt_d = '0;
                        beep_d     = 1'b1;
                    end else begin
                        snz_cnt_d = snz_cnt_q + SW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            ring_cnt_q     <= '0;
            snz_cnt_q      <= '0;
            beep_q         <= 1'b0;
            snooze_count_q <= 2'd0;
            event_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            ring_cnt_q     <= ring_cnt_d;
            snz_cnt_q      <= snz_cnt_d;
            beep_q         <= beep_d;
            snooze_count_q <= snooze_count_d;
            event_q        <= event_d;
        end
    end

    assign ringing      = (state_q == ST_RINGING);
    assign snoozing     = (state_q == ST_SNOOZE);
    assign buzzer       = ringing & beep_q;
    assign snooze_count = snooze_count_q;
    assign alarm_event  = event_q;

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed bench for alarm_trigger with short timing parameters; each step
// is checked by an immediate assertion against hand-computed values.
module tb_alarm_trigger;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz;
    logic       cfg_valid;
    logic       alarm_on;
    logic [1:0] ahl;
    logic [3:0] ahr;
    logic [2:0] aml;
    logic [3:0] amr;
    logic [1:0] thl;
    logic [3:0] thr;
    logic [2:0] tml;
    logic [3:0] tmr;
    logic       stop_button;
    logic       snooze_button;
    logic       buzzer;
    logic       ringing;
    logic       snoozing;
    logic [1:0] snooze_count;
    logic       alarm_event;

    int checks = 0;
    int errors = 0;
    int evCount;

    alarm_trigger #(.RING_TIMEOUT_S(4), .SNOOZE_S(3), .MAX_SNOOZE(2)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .tick_1hz            (tick_1hz),
        .cfg_valid           (cfg_valid),
        .alarm_on            (alarm_on),
        .alarm_hours_left    (ahl),
        .alarm_hours_right   (ahr),
        .alarm_minutes_left  (aml),
        .alarm_minutes_right (amr),
        .time_hours_left     (thl),
        .time_hours_right    (thr),
        .time_minutes_left   (tml),
        .time_minutes_right  (tmr),
        .stop_button         (stop_button),
        .snooze_button       (snooze_button),
        .buzzer              (buzzer),
        .ringing             (ringing),
        .snoozing            (snoozing),
        .snooze_count        (snooze_count),
        .alarm_event         (alarm_event)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after a rising edge, so outputs are stable here.
    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic setTime(input int minutesRight);
        thl = 2'd0;
        thr = 4'd7;
        tml = 3'd3;
        tmr = 4'(minutesRight);
    endtask

    task automatic pulseTick();
        tick_1hz = 1'b1;
        applyStimulus(1);
        tick_1hz = 1'b0;
    endtask

    task automatic pulseSnooze();
        snooze_button = 1'b1;
        applyStimulus(1);
        snooze_button = 1'b0;
    endtask

    task automatic pulseStop();
        stop_button = 1'b1;
        applyStimulus(1);
        stop_button = 1'b0;
    endtask

    task automatic retrigger();
        setTime(1);
        applyStimulus(1);
        setTime(0);
        applyStimulus(1);
    endtask

    initial begin
        rst = 1'b0;
        tick_1hz = 1'b0;
        cfg_valid = 1'b1;
        alarm_on = 1'b1;
        stop_button = 1'b0;
        snooze_button = 1'b0;
        ahl = 2'd0; ahr = 4'd7; aml = 3'd3; amr = 4'd0;
        thl = 2'd0; thr = 4'd7; tml = 3'd2; tmr = 4'd9;
        applyStimulus(2);
        checkOutput("reset_ringing", ringing, 0);
        checkOutput("reset_buzzer", buzzer, 0);
        checkOutput("reset_snoozing", snoozing, 0);
        checkOutput("reset_count", snooze_count, 0);
        checkOutput("reset_event", alarm_event, 0);
        rst = 1'b1;
        applyStimulus(2);
        checkOutput("idle_0729", ringing, 0);

        // Basic ring with auto-silence after four ticks
        setTime(0);
        applyStimulus(1);
        checkOutput("fire_event", alarm_event, 1);
        checkOutput("fire_ringing", ringing, 1);
        checkOutput("fire_buzzer", buzzer, 1);
        applyStimulus(1);
        checkOutput("event_one_cycle", alarm_event, 0);
        pulseTick();
        checkOutput("beep_t1", buzzer, 0);
        pulseTick();
        checkOutput("beep_t2", buzzer, 1);
        pulseTick();
        checkOutput("beep_t3", buzzer, 0);
        checkOutput("ring_t3", ringing, 1);
        pulseTick();
        checkOutput("timeout_ringing", ringing, 0);
        checkOutput("timeout_buzzer", buzzer, 0);
        applyStimulus(3);
        checkOutput("held_no_refire", ringing, 0);

        // Stop on the second tick
        retrigger();
        checkOutput("stop_ring", ringing, 1);
        pulseTick();
        stop_button = 1'b1;
        tick_1hz = 1'b1;
        applyStimulus(1);
        stop_button = 1'b0;
        tick_1hz = 1'b0;
        checkOutput("stop_idle", ringing, 0);
        checkOutput("stop_buzzer", buzzer, 0);
        applyStimulus(3);
        checkOutput("stop_no_refire", ringing, 0);

        // Snooze limit
        retrigger();
        checkOutput("snz_ring", ringing, 1);
        pulseSnooze();
        checkOutput("snz1_snoozing", snoozing, 1);
        checkOutput("snz1_buzzer", buzzer, 0);
        checkOutput("snz1_count", snooze_count, 1);
        pulseTick();
        pulseTick();
        checkOutput("snz1_still", snoozing, 1);
        pulseSnooze();
        checkOutput("snz_in_snooze_count", snooze_count, 1);
        pulseTick();
        checkOutput("snz1_rering", ringing, 1);
        checkOutput("snz1_rering_buzz", buzzer, 1);
        pulseSnooze();
        checkOutput("snz2_count", snooze_count, 2);
        checkOutput("snz2_snoozing", snoozing, 1);
        pulseTick();
        pulseTick();
        pulseTick();
        checkOutput("snz2_rering", ringing, 1);
        pulseSnooze();
        checkOutput("snz3_ignored_ring", ringing, 1);
        checkOutput("snz3_ignored_snz", snoozing, 0);
        checkOutput("snz3_count", snooze_count, 2);
        pulseStop();
        checkOutput("snz_stop_idle", ringing, 0);
        checkOutput("count_holds_idle", snooze_count, 2);

        // alarm_on dropped in SNOOZE, then stop+snooze together
        retrigger();
        checkOutput("retrig_count_clear", snooze_count, 0);
        pulseSnooze();
        checkOutput("pre_off_snoozing", snoozing, 1);
        alarm_on = 1'b0;
        applyStimulus(1);
        checkOutput("off_idle_snz", snoozing, 0);
        checkOutput("off_idle_ring", ringing, 0);
        setTime(1);
        alarm_on = 1'b1;
        applyStimulus(1);
        setTime(0);
        applyStimulus(1);
        checkOutput("both_ring", ringing, 1);
        stop_button = 1'b1;
        snooze_button = 1'b1;
        applyStimulus(1);
        stop_button = 1'b0;
        snooze_button = 1'b0;
        checkOutput("both_idle", ringing, 0);
        checkOutput("both_no_snooze", snoozing, 0);
        checkOutput("both_count", snooze_count, 0);

        // cfg_valid gating and reset mid-ring
        cfg_valid = 1'b0;
        retrigger();
        checkOutput("cfg_no_event", alarm_event, 0);
        checkOutput("cfg_no_ring", ringing, 0);
        setTime(1);
        cfg_valid = 1'b1;
        applyStimulus(1);
        setTime(0);
        applyStimulus(1);
        checkOutput("cfg_ok_ring", ringing, 1);
        rst = 1'b0;
        #1;
        checkOutput("rst_async_ring", ringing, 0);
        checkOutput("rst_async_buzz", buzzer, 0);
        applyStimulus(2);
        rst = 1'b1;
        evCount = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1);
            evCount += int'(alarm_event);
        end
        checkOutput("rst_one_event", evCount, 1);
        checkOutput("rst_refire_ring", ringing, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
